// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with generic width/depth, programmable flags, optional FWFT read and sticky errors
module param_sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc, wr_acc;

    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
    assign rd_acc = rd_en & (count_q != '0);
    assign wr_acc = wr_en & ((count_q != CW'(DEPTH)) | rd_acc);

    // Next-state: flush clears occupancy and suppresses acceptance and error updates.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_d = (wr_acc & ~rd_acc) ? count_q + CW'(1) :
                      (rd_acc & ~wr_acc) ? count_q - CW'(1) : count_q;
            dout_d  = rd_acc ? mem_q[rd_ptr_q] : dout_q;
            ovf_d   = ovf_q | (wr_en & ~wr_acc);
            unf_d   = unf_q | (rd_en & ~rd_acc);
        end
    end

    // State registers with synchronous active-low reset; reset wins over flush and requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out     = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: random and directed checks of two FIFO configurations against a queue model
module tb_param_sync_fifo;
    logic        clk = 1'b0;
    logic        rst_n, flush, wr_en, rd_en;
    logic [31:0] data_in;
    logic [31:0] dout0, dout1;
    logic [3:0]  count0;
    logic [2:0]  count1;
    logic        empty0, full0, ae0, af0, ovf0, unf0;
    logic        empty1, full1, ae1, af1, ovf1, unf1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] m_dout0;
    logic        m_ovf0, m_unf0, m_ovf1, m_unf1;

    always #5 clk = ~clk;

    param_sync_fifo u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    param_sync_fifo #(.WIDTH(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f, input logic n);
        logic ra, wa;
        wr_en = w; data_in = d; rd_en = r; flush = f; rst_n = n;
        @(posedge clk);
        if (!n) begin
            q0.delete(); q1.delete();
            m_dout0 = 0; m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
        end else if (f) begin
            q0.delete(); q1.delete();
        end else begin
            ra = r && q0.size() > 0;
            wa = w && (q0.size() < 8 || ra);
            if (w && !wa) m_ovf0 = 1;
            if (r && !ra) m_unf0 = 1;
            if (ra) m_dout0 = q0.pop_front();
            if (wa) q0.push_back(d);
            ra = r && q1.size() > 0;
            wa = w && (q1.size() < 5 || ra);
            if (w && !wa) m_ovf1 = 1;
            if (r && !ra) m_unf1 = 1;
            if (ra) void'(q1.pop_front());
            if (wa) q1.push_back(d);
        end
        @(negedge clk);
        chk("std_count", 32'(count0), q0.size());
        chk("std_empty", 32'(empty0), 32'(q0.size() == 0));
        chk("std_full",  32'(full0),  32'(q0.size() == 8));
        chk("std_aempty", 32'(ae0),   32'(q0.size() <= 1));
        chk("std_afull", 32'(af0),    32'(q0.size() >= 6));
        chk("std_ovf",   32'(ovf0),   32'(m_ovf0));
        chk("std_unf",   32'(unf0),   32'(m_unf0));
        chk("std_dout",  dout0,       m_dout0);
        chk("fw_count",  32'(count1), q1.size());
        chk("fw_empty",  32'(empty1), 32'(q1.size() == 0));
        chk("fw_full",   32'(full1),  32'(q1.size() == 5));
        chk("fw_aempty", 32'(ae1),    32'(q1.size() <= 1));
        chk("fw_afull",  32'(af1),    32'(q1.size() >= 4));
        chk("fw_ovf",    32'(ovf1),   32'(m_ovf1));
        chk("fw_unf",    32'(unf1),   32'(m_unf1));
        if (q1.size() > 0) chk("fw_dout", dout1, q1[0]);
    endtask

    initial begin
        wr_en = 0; rd_en = 0; flush = 0; rst_n = 0; data_in = 0;
        q0.delete(); q1.delete();
        m_dout0 = 0; m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
        @(negedge clk);
        repeat (2) step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step(1, i, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) step(1, 32'hA0 + r * 3 + i, 0, 0, 1);
            for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        end
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h10 + i, 0, 0, 1);
        step(1, 32'h55, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 1);
        step(1, 32'h66, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 32'hDEAD, 0, 0, 1);
        step(1, 32'hBEEF, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 32'h30 + i, 0, 0, 1);
        step(1, 32'h99, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h40 + i, 1, 0, 1);
        step(1, 32'h77, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 199) != 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
